// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
// rr_pick scans the request vector starting at ptr and wraps modulo N.
package mux_pkg;

   localparam int N    = 8;
   localparam int SELW = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef struct packed {
      logic            found;
      logic [SELW-1:0] idx;
   } pick_t;

   // Scan from N-1 down to 0 so the lowest offset from ptr is written last and wins.
   function automatic pick_t rr_pick(input logic [N-1:0] req, input logic [SELW-1:0] ptr);
      pick_t           p;
      logic [SELW-1:0] k;
      p.found = 1'b0;
      p.idx   = {SELW{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         k = ptr + SELW'(i);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux8to1.sv
// Existing combinational 8:1 bit multiplexer shared by the requesters.
module mux8to1 (
   input  logic [7:0] I,
   input  logic [2:0] S,
   output logic       y_comb
);

   assign y_comb = I[S];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler driving the shared 8:1 mux select from a registered grant
// with a bounded hold time, and registering the selected data bit.
module mux_rr_arbiter #(
   parameter int N        = 8,
   parameter int SELW     = 3,
   parameter int MAX_HOLD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    I,
   output logic [SELW-1:0] S,
   output logic [N-1:0]    gnt,
   output logic            valid,
   output logic            Y
);
   import mux_pkg::*;

   localparam int             HW       = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   state_e          state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [SELW-1:0] s_q, s_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic            y_q, y_d;
   logic            y_comb;
   logic            valid_s;
   pick_t           pick;

   mux8to1 u_mux (
      .I      (I),
      .S      (s_q),
      .y_comb (y_comb)
   );

   assign valid_s = |gnt_q;
   assign pick    = rr_pick(req, ptr_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      s_d     = s_q;
      gnt_d   = gnt_q;
      y_d     = valid_s ? y_comb : 1'b0;
      case (state_q)
         IDLE: begin
            if (pick.found) begin
               s_d     = pick.idx;
               gnt_d   = ONE_HOT0 << pick.idx;
               hold_d  = HW'(1);
               state_d = GRANT;
            end else begin
               gnt_d   = {N{1'b0}};
            end
         end
         GRANT: begin
            // A dropped request or an exhausted hold releases; S keeps the last owner.
            if (req[s_q] && (hold_q < HOLD_MAX)) begin
               hold_d = hold_q + HW'(1);
            end else begin
               gnt_d   = {N{1'b0}};
               hold_d  = {HW{1'b0}};
               ptr_d   = s_q + SELW'(1);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = {N{1'b0}};
            hold_d  = {HW{1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= {SELW{1'b0}};
         hold_q  <= {HW{1'b0}};
         s_q     <= {SELW{1'b0}};
         gnt_q   <= {N{1'b0}};
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         s_q     <= s_d;
         gnt_q   <= gnt_d;
         y_q     <= y_d;
      end
   end

   assign S     = s_q;
   assign gnt   = gnt_q;
   assign valid = valid_s;
   assign Y     = y_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: a MAX_HOLD=4 and a MAX_HOLD=1 instance checked against
// directed constant patterns and a behavioural round-robin model.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_a, i_a, req_b, i_b;
   logic [2:0] s_a, s_b;
   logic [7:0] gnt_a, gnt_b;
   logic       valid_a, valid_b, y_a, y_b;

   int total = 0;
   int bad   = 0;

   // model state per unit (0: MAX_HOLD=4, 1: MAX_HOLD=1); owner -1 means idle
   int   m_owner[2];
   int   m_s[2];
   int   m_ptr[2];
   int   m_hold[2];
   logic m_y[2];
   int   maxh[2] = '{4, 1};

   mux_rr_arbiter #(.N(8), .SELW(3), .MAX_HOLD(4)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .I(i_a),
      .S(s_a), .gnt(gnt_a), .valid(valid_a), .Y(y_a)
   );

   mux_rr_arbiter #(.N(8), .SELW(3), .MAX_HOLD(1)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .I(i_b),
      .S(s_b), .gnt(gnt_b), .valid(valid_b), .Y(y_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         m_owner[u] = -1;
         m_s[u]     = 0;
         m_ptr[u]   = 0;
         m_hold[u]  = 0;
         m_y[u]     = 1'b0;
      end
   endfunction

   function automatic void model_step(input int u, input logic [7:0] r, input logic [7:0] d);
      logic ny;
      int   k;
      ny = (m_owner[u] >= 0) ? d[m_s[u]] : 1'b0;
      if (m_owner[u] < 0) begin
         for (int i = 0; i < 8; i++) begin
            k = (m_ptr[u] + i) % 8;
            if (r[k] && m_owner[u] < 0) begin
               m_owner[u] = k;
               m_s[u]     = k;
               m_hold[u]  = 1;
            end
         end
      end else if (r[m_owner[u]] && m_hold[u] < maxh[u]) begin
         m_hold[u] = m_hold[u] + 1;
      end else begin
         m_ptr[u]   = (m_owner[u] + 1) % 8;
         m_owner[u] = -1;
      end
      m_y[u] = ny;
   endfunction

   function automatic logic [7:0] exp_gnt(input int u);
      logic [7:0] one;
      one = 8'h01;
      return (m_owner[u] >= 0) ? (one << m_owner[u]) : 8'h00;
   endfunction

   task automatic tick();
      logic [7:0] ra, da, rb, db;
      ra = req_a; da = i_a; rb = req_b; db = i_b;
      @(posedge clk);
      model_step(0, ra, da);
      model_step(1, rb, db);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = 8'h00; i_a = 8'h00; req_b = 8'h00; i_b = 8'h00;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      req_a = 8'hFF; i_a = 8'hFF; req_b = 8'hFF; i_b = 8'hFF;
      #1 rst_n = 1'b0;
      #2;
      total++;
      if ({s_a, gnt_a, valid_a, y_a} !== 13'd0) begin
         bad++;
         $display("FAIL reset_a: got S=%0d gnt=%h valid=%b Y=%b, need all 0", s_a, gnt_a, valid_a, y_a);
      end
      total++;
      if ({s_b, gnt_b, valid_b, y_b} !== 13'd0) begin
         bad++;
         $display("FAIL reset_b: got S=%0d gnt=%h valid=%b Y=%b, need all 0", s_b, gnt_b, valid_b, y_b);
      end
      @(posedge clk); #1;
      total++;
      if (gnt_a !== 8'h00 || valid_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: got gnt=%h valid=%b with rst_n low, need 0", gnt_a, valid_a);
      end
      do_reset();
   endtask

   task automatic test_single();
      logic exp_y;
      do_reset();
      req_a = 8'h20; i_a = 8'h20;
      for (int c = 0; c < 15; c++) begin
         tick();
         total++;
         if (gnt_a !== ((c % 5 < 4) ? 8'h20 : 8'h00)) begin
            bad++;
            $display("FAIL single_gnt c=%0d: got %h, need %h", c, gnt_a, (c % 5 < 4) ? 8'h20 : 8'h00);
         end
         exp_y = (c > 0) && ((c - 1) % 5 < 4);
         total++;
         if (y_a !== exp_y) begin
            bad++;
            $display("FAIL single_y c=%0d: got %b, need %b", c, y_a, exp_y);
         end
      end
   endtask

   task automatic test_fairness();
      logic [7:0] one, ea, eb;
      one = 8'h01;
      do_reset();
      req_a = 8'hFF; req_b = 8'hFF;
      for (int c = 0; c < 45; c++) begin
         tick();
         ea = (c % 5 < 4) ? (one << ((c / 5) % 8)) : 8'h00;
         eb = (c % 2 == 0) ? (one << ((c / 2) % 8)) : 8'h00;
         total++;
         if (gnt_a !== ea || s_a !== 3'((c / 5) % 8)) begin
            bad++;
            $display("FAIL fair_a c=%0d: got gnt=%h S=%0d, need gnt=%h S=%0d", c, gnt_a, s_a, ea, (c / 5) % 8);
         end
         total++;
         if (gnt_b !== eb || s_b !== 3'((c / 2) % 8)) begin
            bad++;
            $display("FAIL fair_b c=%0d: got gnt=%h S=%0d, need gnt=%h S=%0d", c, gnt_b, s_b, eb, (c / 2) % 8);
         end
      end
   endtask

   task automatic test_early_drop();
      logic [7:0] exp_seq [9] = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
      do_reset();
      req_a = 8'h81;
      for (int c = 0; c < 9; c++) begin
         tick();
         total++;
         if (gnt_a !== exp_seq[c]) begin
            bad++;
            $display("FAIL early_drop c=%0d: got gnt=%h, need %h", c, gnt_a, exp_seq[c]);
         end
         if (c == 1) req_a = 8'h80;
         if (c == 3) req_a = 8'h81;
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req_a = 8'h08; i_a = 8'h08;
      tick();
      total++;
      if (s_a !== 3'd3 || gnt_a !== 8'h08) begin
         bad++;
         $display("FAIL midrst_grant: got S=%0d gnt=%h, need S=3 gnt=08", s_a, gnt_a);
      end
      tick();
      total++;
      if (y_a !== 1'b1) begin
         bad++;
         $display("FAIL midrst_y: got Y=%b, need 1", y_a);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (s_a !== 3'd0 || gnt_a !== 8'h00 || valid_a !== 1'b0 || y_a !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async: got S=%0d gnt=%h valid=%b Y=%b, need all 0", s_a, gnt_a, valid_a, y_a);
      end
      rst_n = 1'b1;
      req_a = 8'h08;
      tick();
      total++;
      if (s_a !== 3'd3 || gnt_a !== 8'h08 || valid_a !== 1'b1) begin
         bad++;
         $display("FAIL midrst_regrant: got S=%0d gnt=%h valid=%b, need S=3 gnt=08 valid=1", s_a, gnt_a, valid_a);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         if ($urandom_range(3) == 0) req_a = 8'($urandom);
         if ($urandom_range(3) == 0) req_b = 8'($urandom);
         i_a = 8'($urandom);
         i_b = 8'($urandom);
         tick();
         total++;
         if (gnt_a !== exp_gnt(0) || s_a !== 3'(m_s[0]) || y_a !== m_y[0]) begin
            bad++;
            $display("FAIL rand_a c=%0d: got gnt=%h S=%0d Y=%b, need gnt=%h S=%0d Y=%b",
                     c, gnt_a, s_a, y_a, exp_gnt(0), m_s[0], m_y[0]);
         end
         total++;
         if (gnt_b !== exp_gnt(1) || s_b !== 3'(m_s[1]) || y_b !== m_y[1]) begin
            bad++;
            $display("FAIL rand_b c=%0d: got gnt=%h S=%0d Y=%b, need gnt=%h S=%0d Y=%b",
                     c, gnt_b, s_b, y_b, exp_gnt(1), m_s[1], m_y[1]);
         end
         total++;
         if ($countones(gnt_a) > 1 || valid_a !== (m_owner[0] >= 0) || valid_b !== (m_owner[1] >= 0)) begin
            bad++;
            $display("FAIL rand_valid c=%0d: got gnt_a=%h valid_a=%b valid_b=%b, need one-hot and valid %b/%b",
                     c, gnt_a, valid_a, valid_b, m_owner[0] >= 0, m_owner[1] >= 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_early_drop();
      test_reset_mid_grant();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
